invader_hit_detect: RTL and testbench

//  Tracks which invaders in the formation are alive and detects player-bullet hits.

---
 rtl/invaders_pkg.sv | 58 +++++
 rtl/invader_box_hit.sv | 35 +++
 rtl/invader_hit_detect.sv | 179 +++++++++++++++++
 tb/tb_invader_hit_detect.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/invaders_pkg.sv
// Shared definitions for the invaders formation blocks (movement, hit
// detection, renderer).
//   - Formation geometry: rows/columns, cell pitch, invader hit-box size.
//   - Formation start position used by the movement block on a new wave.
//   - Hit-detection FSM state encoding.
//   - Helpers to place a cell within the formation.
package invaders_pkg;

  localparam int unsigned ROWS    = 5;   // row 0 = top
  localparam int unsigned COLS    = 11;  // col 0 = left
  localparam int unsigned PITCH_X = 16;  // pixels between cell origins
  localparam int unsigned PITCH_Y = 16;
  localparam int unsigned SPR_W   = 12;  // invader hit-box size, pixels
  localparam int unsigned SPR_H   = 8;

  localparam int unsigned N_CELLS = ROWS * COLS;

  localparam int unsigned INVADERS_START_X = 24;
  localparam int unsigned INVADERS_START_Y = 32;

  // Screen coordinates are 10 bits; formation arithmetic uses one extra bit
  // so a formation whose origin sits near 1023 does not wrap to the left edge.
  localparam int unsigned COORD_W = 10;
  localparam int unsigned ARITH_W = 11;

  localparam int unsigned IDX_W = 6;  // enough for N_CELLS-1
  localparam int unsigned ROW_W = 3;
  localparam int unsigned COL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } hit_state_e;

  // Pixel position of a cell origin along one axis: origin + slot*pitch,
  // widened to ARITH_W bits.
  function automatic logic [ARITH_W-1:0] cell_origin(
    input logic [COORD_W-1:0] origin,
    input logic [COL_W-1:0]   slot,
    input int unsigned        pitch
  );
    logic [31:0] offset;
    offset = 32'(slot) * pitch;
    return ARITH_W'(origin) + offset[ARITH_W-1:0];
  endfunction

  // Flat alive-mask index of a (row, col) cell.
  function automatic logic [IDX_W-1:0] cell_index(
    input logic [ROW_W-1:0] row,
    input logic [COL_W-1:0] col
  );
    logic [31:0] flat;
    flat = 32'(row) * COLS + 32'(col);
    return flat[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/invader_box_hit.sv
// Point-in-box test used for player bullet vs invader and enemy bullet vs
// player checks. Purely combinational.
// Ports:
//   cx, cy : box top-left corner (ARITH_W bits, unsigned)
//   bx, by : point to test (ARITH_W bits, unsigned)
//   hit    : 1 when cx <= bx < cx+BOX_W and cy <= by < cy+BOX_H
module invader_box_hit
  import invaders_pkg::*;
#(
  parameter int unsigned BOX_W = SPR_W,
  parameter int unsigned BOX_H = SPR_H
) (
  input  logic [ARITH_W-1:0] cx,
  input  logic [ARITH_W-1:0] cy,
  input  logic [ARITH_W-1:0] bx,
  input  logic [ARITH_W-1:0] by,
  output logic               hit
);

  // One more bit for the far edges so a box touching the top of the
  // arithmetic range still compares correctly.
  logic [ARITH_W:0] x_end;
  logic [ARITH_W:0] y_end;
  logic             in_x;
  logic             in_y;

  assign x_end = {1'b0, cx} + (ARITH_W+1)'(BOX_W);
  assign y_end = {1'b0, cy} + (ARITH_W+1)'(BOX_H);

  assign in_x = (bx >= cx) && ({1'b0, bx} < x_end);
  assign in_y = (by >= cy) && ({1'b0, by} < y_end);

  assign hit = in_x && in_y;

endmodule

// File: rtl/invader_hit_detect.sv
// Tracks which invaders of the formation are alive and detects player bullet
// hits. Once per frame (when a bullet is in flight) the formation is scanned
// one cell per cycle; the first live cell containing the bullet tip is killed.
// Ports:
//   clk               system clock
//   rst_n             asynchronous reset, active-low
//   frame             1-cycle pulse at start of vblank, starts a scan
//   wave_reload       revive all invaders and abort any scan (highest priority)
//   invaders_x/_y     formation origin, pixels
//   bullet_active     player bullet in flight
//   bullet_x/_y       bullet tip position, pixels
//   alive             bit row*COLS+col set while that invader lives
//   invader_collision 1-cycle pulse when an invader is killed
//   hit_index/hit_row index and row of the last invader killed (held)
//   all_dead          registered, set once every invader is dead
//   busy              high while a scan (SCAN or DONE) is in progress
module invader_hit_detect
  import invaders_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame,
  input  logic               wave_reload,
  input  logic [COORD_W-1:0] invaders_x,
  input  logic [COORD_W-1:0] invaders_y,
  input  logic               bullet_active,
  input  logic [COORD_W-1:0] bullet_x,
  input  logic [COORD_W-1:0] bullet_y,
  output logic [N_CELLS-1:0] alive,
  output logic               invader_collision,
  output logic [IDX_W-1:0]   hit_index,
  output logic [ROW_W-1:0]   hit_row,
  output logic               all_dead,
  output logic               busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CELLS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  hit_state_e         state_q;

  // Shadow copies of the positions, frozen for the whole scan.
  logic [COORD_W-1:0] ox_q;
  logic [COORD_W-1:0] oy_q;
  logic [COORD_W-1:0] bx_q;
  logic [COORD_W-1:0] by_q;

  // Scan position kept as flat index plus row/col counters (no divider).
  logic [IDX_W-1:0]   idx_q;
  logic [ROW_W-1:0]   row_q;
  logic [COL_W-1:0]   col_q;

  logic [N_CELLS-1:0] alive_q;
  logic [N_CELLS-1:0] alive_d;
  logic               collision_q;
  logic [IDX_W-1:0]   hit_index_q;
  logic [ROW_W-1:0]   hit_row_q;
  logic               all_dead_q;
  logic               busy_q;

  logic [ARITH_W-1:0] cell_x;
  logic [ARITH_W-1:0] cell_y;
  logic [ARITH_W-1:0] tip_x;
  logic [ARITH_W-1:0] tip_y;
  logic               box_hit;
  logic               scan_hit;
  logic [N_CELLS-1:0] kill_vec;

  // Position of the cell under test.
  assign cell_x = cell_origin(ox_q, col_q, PITCH_X);
  assign cell_y = cell_origin(oy_q, COL_W'(row_q), PITCH_Y);
  assign tip_x  = ARITH_W'(bx_q);
  assign tip_y  = ARITH_W'(by_q);

  invader_box_hit #(
    .BOX_W(SPR_W),
    .BOX_H(SPR_H)
  ) u_box_hit (
    .cx (cell_x),
    .cy (cell_y),
    .bx (tip_x),
    .by (tip_y),
    .hit(box_hit)
  );

  // Dead cells are transparent to the bullet.
  assign scan_hit = (state_q == ST_SCAN) && alive_q[idx_q] && box_hit;

  // One-hot kill decode of the cell under test.
  generate
    for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_kill
      assign kill_vec[gi] = scan_hit && (idx_q == IDX_W'(gi));
    end
  endgenerate

  assign alive_d = alive_q & ~kill_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ox_q        <= '0;
      oy_q        <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      idx_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      alive_q     <= '1;
      collision_q <= 1'b0;
      hit_index_q <= '0;
      hit_row_q   <= '0;
      all_dead_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      collision_q <= 1'b0;
      if (wave_reload) begin
        // Reload overrides everything; last-hit info is deliberately kept.
        state_q    <= ST_IDLE;
        alive_q    <= '1;
        all_dead_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        // Follows the registered mask, so it rises the cycle after the kill.
        all_dead_q <= (alive_q == '0);
        unique case (state_q)
          ST_IDLE: begin
            if (frame && bullet_active) begin
              ox_q    <= invaders_x;
              oy_q    <= invaders_y;
              bx_q    <= bullet_x;
              by_q    <= bullet_y;
              idx_q   <= '0;
              row_q   <= '0;
              col_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_SCAN;
            end
          end
          ST_SCAN: begin
            if (scan_hit) begin
              // First hit ends the scan: at most one kill per frame.
              alive_q     <= alive_d;
              collision_q <= 1'b1;
              hit_index_q <= idx_q;
              hit_row_q   <= row_q;
              state_q     <= ST_DONE;
            end else if (idx_q == LAST_IDX) begin
              state_q <= ST_DONE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              if (col_q == LAST_COL) begin
                col_q <= '0;
                row_q <= row_q + ROW_W'(1);
              end else begin
                col_q <= col_q + COL_W'(1);
              end
            end
          end
          ST_DONE: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign alive             = alive_q;
  assign invader_collision = collision_q;
  assign hit_index         = hit_index_q;
  assign hit_row           = hit_row_q;
  assign all_dead          = all_dead_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_invader_hit_detect.sv
module tb_invader_hit_detect;

  localparam int NC = 55;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame;
  logic          wave_reload;
  logic [9:0]    invaders_x;
  logic [9:0]    invaders_y;
  logic          bullet_active;
  logic [9:0]    bullet_x;
  logic [9:0]    bullet_y;
  logic [NC-1:0] alive;
  logic          invader_collision;
  logic [5:0]    hit_index;
  logic [2:0]    hit_row;
  logic          all_dead;
  logic          busy;

  invader_hit_detect dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame            (frame),
    .wave_reload      (wave_reload),
    .invaders_x       (invaders_x),
    .invaders_y       (invaders_y),
    .bullet_active    (bullet_active),
    .bullet_x         (bullet_x),
    .bullet_y         (bullet_y),
    .alive            (alive),
    .invader_collision(invader_collision),
    .hit_index        (hit_index),
    .hit_row          (hit_row),
    .all_dead         (all_dead),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected outcome of one accepted scan, offsets relative to the frame cycle.
  typedef struct {
    int          fc;
    bit          pulse;
    int          idx;
    int          row;
    int          pulse_off;
    int          end_off;
    bit [NC-1:0] alive;
    int          hold_idx;
    int          hold_row;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  bit [NC-1:0] alive_m;
  int          last_idx = 0;
  int          last_row = 0;
  int          model_free = 0;  // first cycle the block can accept a frame

  // First live invader whose box contains the bullet tip, scanning row-major.
  function automatic int first_hit(input int ox, input int oy, input int bx, input int by);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 11; c++) begin
        int x0 = ox + c * 16;
        int y0 = oy + r * 16;
        if (alive_m[r*11+c] && bx >= x0 && bx < x0 + 12 && by >= y0 && by < y0 + 8)
          return r * 11 + c;
      end
    end
    return -1;
  endfunction

  // Monitor / scoreboard
  bit busy_prev = 1'b0;
  int npulse = 0;
  int p_cyc = 0;
  int p_idx = 0;
  int p_row = 0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (invader_collision) begin
          npulse++;
          p_cyc = cyc;
          p_idx = int'(hit_index);
          p_row = int'(hit_row);
          check("dead_at_pulse", all_dead, 0);
        end
        if (busy_prev && !busy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_scan", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            $display("scan fc=%0d pulses=%0d idx=%0d row=%0d end_off=%0d",
                     e.fc, npulse, p_idx, p_row, cyc - e.fc);
            check("pulse_count", npulse, e.pulse ? 1 : 0);
            if (e.pulse && npulse == 1) begin
              check("pulse_idx", p_idx, e.idx);
              check("pulse_row", p_row, e.row);
              check("pulse_cycle", p_cyc - e.fc, e.pulse_off);
            end
            check("end_cycle", cyc - e.fc, e.end_off);
            check("alive", alive, e.alive);
            check("hold_idx", hit_index, e.hold_idx);
            check("hold_row", hit_row, e.hold_row);
            check("all_dead", all_dead, (e.alive == '0) ? 1 : 0);
          end
          npulse = 0;
        end
        busy_prev = busy;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reload();
    wave_reload = 1'b1;
    tick();
    wave_reload = 1'b0;
    alive_m = '1;
    check("reload_alive", alive, alive_m);
    check("reload_dead", all_dead, 0);
    check("reload_busy", busy, 0);
  endtask

  // One frame: drive positions, predict, then run until the scan completes.
  // reload_off/drop_off > 0 inject wave_reload / an extra frame at that cycle.
  task automatic run_scan(input int ox, input int oy, input int bx, input int by,
                          input bit act, input int reload_off, input int drop_off);
    int fc;
    int k;
    int t;
    exp_t e;
    invaders_x    = 10'(ox);
    invaders_y    = 10'(oy);
    bullet_x      = 10'(bx);
    bullet_y      = 10'(by);
    bullet_active = act;
    frame         = 1'b1;
    fc            = cyc;
    if (act && fc >= model_free) begin
      e.fc    = fc;
      e.pulse = 1'b0;
      e.idx   = 0;
      e.row   = 0;
      e.pulse_off = 0;
      k = first_hit(ox, oy, bx, by);
      if (reload_off > 0) begin
        e.end_off = reload_off + 1;
        alive_m = '1;
      end else if (k >= 0) begin
        e.pulse     = 1'b1;
        e.idx       = k;
        e.row       = k / 11;
        e.pulse_off = k + 2;
        e.end_off   = k + 3;
        alive_m[k]  = 1'b0;
        last_idx    = k;
        last_row    = k / 11;
      end else begin
        e.end_off = 57;
      end
      e.alive    = alive_m;
      e.hold_idx = last_idx;
      e.hold_row = last_row;
      exp_q.push_back(e);
      model_free = fc + e.end_off;
    end
    t = 0;
    while ((exp_q.size() != 0 || t < 3) && t < 200) begin
      tick();
      t++;
      frame       = (t == drop_off);
      wave_reload = (t == reload_off);
      if (t == 3) begin
        // Live inputs wander mid-scan; the scan must use its frozen copies.
        invaders_x = 10'($urandom_range(0, 1023));
        invaders_y = 10'($urandom_range(0, 1023));
        bullet_x   = 10'($urandom_range(0, 1023));
        bullet_y   = 10'($urandom_range(0, 1023));
      end
    end
    frame       = 1'b0;
    wave_reload = 1'b0;
    if (exp_q.size() != 0) begin
      check("scan_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    if (reload_off > 0) check("reload_alive_after", alive, alive_m);
  endtask

  int xs[5] = '{112, 111, 124, 128, 140};

  initial begin : stimulus
    int ox;
    int oy;
    rst_n         = 1'b0;
    frame         = 1'b0;
    wave_reload   = 1'b0;
    invaders_x    = '0;
    invaders_y    = '0;
    bullet_active = 1'b0;
    bullet_x      = '0;
    bullet_y      = '0;
    alive_m       = '1;
    repeat (3) tick();
    check("rst_alive", alive, alive_m);
    check("rst_busy", busy, 0);
    check("rst_all_dead", all_dead, 0);
    check("rst_pulse", invader_collision, 0);
    check("rst_hit_index", hit_index, 0);
    check("rst_hit_row", hit_row, 0);
    rst_n = 1'b1;
    tick();
    model_free = cyc;

    // Directed hit on row 1 col 2, then the same bullet again on a dead cell.
    run_scan(100, 50, 135, 70, 1'b1, 0, 0);
    run_scan(100, 50, 135, 70, 1'b1, 0, 0);

    // Hit-box edges for two formation origins.
    for (int i = 0; i < 5; i++) begin
      do_reload();
      run_scan(100, 50, xs[i], 50, 1'b1, 0, 0);
      do_reload();
      run_scan(112, 50, xs[i], 50, 1'b1, 0, 0);
    end

    // Origin near the right edge must not wrap back to low x.
    do_reload();
    run_scan(1015, 100, 10, 100, 1'b1, 0, 0);
    run_scan(1015, 100, 1020, 104, 1'b1, 0, 0);

    // Inactive bullet: frame ignored.
    run_scan(100, 50, 105, 52, 1'b0, 0, 0);

    // Reload mid-scan while cell 20 is under test.
    run_scan(100, 50, 5, 5, 1'b1, 21, 0);

    // Randomized frames around the formation.
    for (int i = 0; i < 40; i++) begin
      ox = $urandom_range(0, 1023);
      oy = $urandom_range(0, 1023);
      run_scan(ox, oy,
               (ox + $urandom_range(0, 190) > 1023) ? 1023 : ox + $urandom_range(0, 190),
               (oy + $urandom_range(0, 80) > 1023) ? 1023 : oy + $urandom_range(0, 80),
               ($urandom_range(0, 3) != 0), 0, 0);
    end

    // Kill the whole wave, one invader per frame, with dropped frames.
    do_reload();
    ox = $urandom_range(0, 800);
    oy = $urandom_range(0, 600);
    for (int k = 0; k < NC; k++) begin
      run_scan(ox, oy,
               ox + (k % 11) * 16 + $urandom_range(0, 11),
               oy + (k / 11) * 16 + $urandom_range(0, 7),
               1'b1, 0, (k % 5 == 0) ? 2 : 0);
    end
    run_scan(ox, oy, ox + 3, oy + 3, 1'b1, 0, 0);
    check("all_dead_held", all_dead, (alive_m == '0) ? 1 : 0);
    do_reload();
    tick();
    check("all_dead_cleared", all_dead, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
